match_ctrl: RTL and testbench
=============================

Name: match_ctrl

Overview:
- Match-flow controller for the PikaBall game.
- Sequences the two player datapaths and the ball through a repeating cycle: hold in reset → serve → rally → point → next serve.
- Detects ball grounding on each half of the court from the ball's buffer coordinates, keeps score, and declares the winner.
- Sits between the debounced start button and the player/ball modules. It drives their shared active-low hold and the ball launch pulse.

Parameters:
- VBUF_W, 320, video buffer width in pixels.
- NET_X, 160, x coordinate of the net. Ball centre < NET_X is the left half.
- GROUND_Y, 199, ball bottom-edge y at or beyond which the ball counts as grounded.
- BALL_W, 40, ball width in pixels; half-width is used for the centre calculation.
- WIN_SCORE, 15, points needed to win; must be ≤ 15.
- SETUP_CYCLES, 4, cycles obj_rst_n is held low in SETUP.
- SERVE_CYCLES, 50_000_000, delay from SERVE entry to launch (0.5 s at 100 MHz).
- PAUSE_CYCLES, 100_000_000, post-point freeze length.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start_btn  in  1  debounced start level; rising edge is detected internally.
- ball_x  in  12  left edge of ball, buffer coordinates.
- ball_y  in  12  bottom edge of ball, buffer coordinates.
- obj_rst_n  out  1  active-low hold for player and ball modules.
- serve_side  out  1  side that serves next: 0 = left, 1 = right.
- ball_launch  out  1  one-cycle pulse that releases the ball.
- score_l  out  4  left player score.
- score_r  out  4  right player score.
- winner  out  2  00 = none, 01 = left, 10 = right.
- state  out  3  current FSM state, for the HUD and for debug.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE, obj_rst_n = 0, serve_side = 1, ball_launch = 0.
  - score_l = score_r = 0, winner = 00.
  - Timer cleared, start edge register cleared, ground filter cleared.
- All outputs are registered. A start edge means start_btn = 1 while its previous-cycle sample = 0.
- IDLE (0):
  - obj_rst_n = 0.
  - On a start edge: clear scores and winner, set serve_side = 1, go to SETUP.
- SETUP (1):
  - obj_rst_n = 0 for exactly SETUP_CYCLES cycles, then go to SERVE.
- SERVE (2):
  - obj_rst_n = 1; timer loads SERVE_CYCLES-1 on entry.
  - When the timer reaches 0, ball_launch = 1 for exactly one cycle (the cycle of the transition) and the FSM enters RALLY.
- RALLY (3):
  - Ground filter: grounded = ball_y ≥ GROUND_Y (unsigned) on two consecutive cycles.
  - On grounded, compute centre = ball_x + BALL_W/2 in 13 bits.
    - centre < NET_X: ball landed left, right player scores.
    - centre ≥ NET_X (including exactly NET_X): left player scores.
  - Increment the scorer's score and set serve_side to the scorer.
  - If the new score == WIN_SCORE: set winner and go to OVER. Otherwise go to POINT.
- POINT (4):
  - obj_rst_n stays 1 (objects freeze naturally). Timer runs PAUSE_CYCLES, then go to SETUP.
- OVER (5):
  - obj_rst_n = 0; winner and scores are held.
  - On a start edge: clear scores and winner, set serve_side = 1, go to SETUP.
- Start edges in SETUP, SERVE, RALLY and POINT are ignored.
- Scores saturate at WIN_SCORE; they never wrap.
- A grounded condition that persists across the POINT→SETUP transition does not score again. The filter is cleared on RALLY entry.
- Undefined state encodings go to IDLE.
- Asserting reset_n mid-rally takes effect immediately and returns to the reset values above.

Decomposition:
- Package pika_pkg holds:
  - state encodings IDLE..OVER;
  - VBUF_W, VBUF_H, NET_X, GROUND_Y, BALL_W;
  - the winner codes.
- One sub-module, match_timer: a 27-bit loadable down-counter.
  - Inputs: load, load_val.
  - Output: expired (count == 0).
  - Shared by SETUP, SERVE and POINT.

Test Plan (simulate with SETUP_CYCLES = 4, SERVE_CYCLES = 10, PAUSE_CYCLES = 20, WIN_SCORE = 3):
- Reset, then pulse start_btn → state 0→1; obj_rst_n low for 4 cycles; SERVE; ball_launch high exactly one cycle 10 cycles after SERVE entry; state = 3.
- In RALLY, drive ball_x = 50, ball_y = 199 for 2 cycles → score_r = 1, serve_side = 1, state = POINT; after 20 cycles state = SETUP.
- Drive ball_x = 140, ball_y = 205 (centre = 160 = NET_X) → score_l increments, serve_side = 0.
- Drive ball_y = 199 for one cycle only, then 150 → no score change, state stays RALLY.
- Right player scores 3 points → winner = 10, state = OVER, obj_rst_n = 0; further grounding does not change scores; start edge → scores 0, winner 00, SETUP.
- Pulse start during RALLY → ignored. Assert reset_n low mid-SERVE between clock edges → outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/pika_pkg.sv
// Shared types and court geometry for the PikaBall match logic.
package pika_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SERVE = 3'd2,
    ST_RALLY = 3'd3,
    ST_POINT = 3'd4,
    ST_OVER  = 3'd5
  } state_e;

  localparam int VBUF_W   = 320;
  localparam int VBUF_H   = 200;
  localparam int NET_X    = 160;
  localparam int GROUND_Y = 199;
  localparam int BALL_W   = 40;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  // Score increment that sticks at the winning score instead of wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] s, input logic [3:0] lim);
    return (s >= lim) ? lim : s + 4'd1;
  endfunction

endpackage

// File: rtl/match_timer.sv
// Loadable down-counter; holds at zero and flags expiry.
module match_timer #(
  parameter int W = 27
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)               cnt_d = load_val;
    else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/match_ctrl.sv
// Match-flow FSM: serve / rally / point sequencing, grounding detection, scoring.
module match_ctrl
  import pika_pkg::*;
#(
  parameter int SETUP_CYCLES = 4,
  parameter int SERVE_CYCLES = 50_000_000,
  parameter int PAUSE_CYCLES = 100_000_000,
  parameter int WIN_SCORE    = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_btn,
  input  logic [11:0] ball_x,
  input  logic [11:0] ball_y,
  output logic        obj_rst_n,
  output logic        serve_side,
  output logic        ball_launch,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic [1:0]  winner,
  output logic [2:0]  state
);

  localparam logic [26:0] SETUP_LD = 27'(SETUP_CYCLES - 1);
  localparam logic [26:0] SERVE_LD = 27'(SERVE_CYCLES - 1);
  localparam logic [26:0] PAUSE_LD = 27'(PAUSE_CYCLES - 1);
  localparam logic [3:0]  WIN_LIM  = 4'(WIN_SCORE);

  state_e      state_q, state_d;
  logic [3:0]  sl_q, sl_d, sr_q, sr_d;
  logic [1:0]  win_q, win_d;
  logic        side_q, side_d;
  logic        launch_q, launch_d;
  logic        orst_q, orst_d;
  logic        start_q, gnd_q;

  logic        tmr_load, tmr_exp;
  logic [26:0] tmr_val;

  logic        start_edge, y_low, grounded, land_left;
  logic [12:0] centre;
  logic [3:0]  new_score;

  assign start_edge = start_btn & ~start_q;
  assign y_low      = (ball_y >= 12'(GROUND_Y));
  // Two consecutive low samples; gnd_q only accumulates while rallying.
  assign grounded   = (state_q == ST_RALLY) && gnd_q && y_low;
  assign centre     = {1'b0, ball_x} + 13'(BALL_W / 2);
  assign land_left  = (centre < 13'(NET_X));
  assign new_score  = land_left ? sat_inc(sr_q, WIN_LIM) : sat_inc(sl_q, WIN_LIM);

  match_timer #(.W(27)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  always_comb begin
    state_d  = state_q;
    sl_d     = sl_q;
    sr_d     = sr_q;
    win_d    = win_q;
    side_d   = side_q;
    launch_d = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_edge) begin
          sl_d     = '0;
          sr_d     = '0;
          win_d    = WIN_NONE;
          side_d   = 1'b1;
          state_d  = ST_SETUP;
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (tmr_exp) begin
          state_d  = ST_SERVE;
          tmr_load = 1'b1;
          tmr_val  = SERVE_LD;
        end
      end
      ST_SERVE: begin
        if (tmr_exp) begin
          launch_d = 1'b1;
          state_d  = ST_RALLY;
        end
      end
      ST_RALLY: begin
        if (grounded) begin
          if (land_left) begin
            sr_d   = new_score;
            side_d = 1'b1;
          end else begin
            sl_d   = new_score;
            side_d = 1'b0;
          end
          if (new_score == WIN_LIM) begin
            win_d   = land_left ? WIN_RIGHT : WIN_LEFT;
            state_d = ST_OVER;
          end else begin
            state_d  = ST_POINT;
            tmr_load = 1'b1;
            tmr_val  = PAUSE_LD;
          end
        end
      end
      ST_POINT: begin
        if (tmr_exp) begin
          state_d  = ST_SETUP;
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    orst_d = (state_d == ST_SERVE) || (state_d == ST_RALLY) || (state_d == ST_POINT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      sl_q     <= '0;
      sr_q     <= '0;
      win_q    <= WIN_NONE;
      side_q   <= 1'b1;
      launch_q <= 1'b0;
      orst_q   <= 1'b0;
      start_q  <= 1'b0;
      gnd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sl_q     <= sl_d;
      sr_q     <= sr_d;
      win_q    <= win_d;
      side_q   <= side_d;
      launch_q <= launch_d;
      orst_q   <= orst_d;
      start_q  <= start_btn;
      gnd_q    <= (state_q == ST_RALLY) ? y_low : 1'b0;
    end
  end

  assign obj_rst_n   = orst_q;
  assign serve_side  = side_q;
  assign ball_launch = launch_q;
  assign score_l     = sl_q;
  assign score_r     = sr_q;
  assign winner      = win_q;
  assign state       = state_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Scoreboard bench: expected output snapshots queued by stimulus, checked on every output change.
module tb_match_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start_btn = 1'b0;
  logic [11:0] ball_x = '0;
  logic [11:0] ball_y = 12'd150;
  logic        obj_rst_n, serve_side, ball_launch;
  logic [3:0]  score_l, score_r;
  logic [1:0]  winner;
  logic [2:0]  state;

  match_ctrl #(
    .SETUP_CYCLES(4), .SERVE_CYCLES(10), .PAUSE_CYCLES(20), .WIN_SCORE(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start_btn(start_btn),
    .ball_x(ball_x), .ball_y(ball_y),
    .obj_rst_n(obj_rst_n), .serve_side(serve_side), .ball_launch(ball_launch),
    .score_l(score_l), .score_r(score_r), .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] snap;
    int          dwell;   // cycles since previous output change, -1 = don't care
  } rec_t;

  rec_t exp_q[$];
  int   total = 0;
  int   passed = 0;

  // snap = {state, score_l, score_r, serve_side, winner, obj_rst_n, ball_launch}
  task automatic push(input logic [2:0] st, input logic [3:0] sl, input logic [3:0] sr,
                      input logic side, input logic [1:0] win, input logic orst,
                      input logic launch, input int dwell);
    rec_t r;
    r.snap  = {st, sl, sr, side, win, orst, launch};
    r.dwell = dwell;
    exp_q.push_back(r);
  endtask

  // Serve sequence that follows a SETUP entry: SERVE, RALLY with launch, launch drop.
  task automatic push_serve(input logic [3:0] sl, input logic [3:0] sr, input logic side);
    push(3'd2, sl, sr, side, 2'b00, 1'b1, 1'b0, 4);
    push(3'd3, sl, sr, side, 2'b00, 1'b1, 1'b1, 10);
    push(3'd3, sl, sr, side, 2'b00, 1'b1, 1'b0, 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL drain_timeout: %0d expected events outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic press_start();
    @(negedge clk);
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
  endtask

  task automatic ground(input logic [11:0] x, input logic [11:0] y);
    @(negedge clk);
    ball_x = x;
    ball_y = y;
  endtask

  // Monitor: every change of the output vector pops one expectation.
  initial begin
    logic [15:0] prev, cur;
    bit   first = 1'b1;
    int   dwell = 0;
    rec_t r;
    prev = '0;
    forever begin
      @(negedge clk);
      dwell++;
      cur = {state, score_l, score_r, serve_side, winner, obj_rst_n, ball_launch};
      if (first || cur != prev) begin
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_event: got %h (dwell %0d), required no change", cur, dwell);
        end else begin
          r = exp_q.pop_front();
          if (cur !== r.snap || (r.dwell >= 0 && dwell != r.dwell))
            $display("FAIL event_st%0d: got snap %h dwell %0d, required snap %h dwell %0d",
                     r.snap[15:13], cur, dwell, r.snap, r.dwell);
          else
            passed++;
        end
        dwell = 0;
        first = 1'b0;
      end
      prev = cur;
    end
  end

  initial begin
    push(3'd0, 4'd0, 4'd0, 1'b1, 2'b00, 1'b0, 1'b0, -1);
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_drain();

    // First serve from IDLE
    push(3'd1, 4'd0, 4'd0, 1'b1, 2'b00, 1'b0, 1'b0, -1);
    push_serve(4'd0, 4'd0, 1'b1);
    press_start();
    wait_drain();

    // Landing left (centre 70): right scores; ground held into POINT must not rescore
    push(3'd4, 4'd0, 4'd1, 1'b1, 2'b00, 1'b1, 1'b0, -1);
    ground(12'd50, 12'd199);
    wait_drain();
    push(3'd1, 4'd0, 4'd1, 1'b1, 2'b00, 1'b0, 1'b0, 20);
    push_serve(4'd0, 4'd1, 1'b1);
    repeat (8) @(negedge clk);
    ball_y = 12'd150;
    wait_drain();

    // Centre exactly on the net: left scores
    push(3'd4, 4'd1, 4'd1, 1'b0, 2'b00, 1'b1, 1'b0, -1);
    ground(12'd140, 12'd205);
    wait_drain();
    ball_y = 12'd150;
    push(3'd1, 4'd1, 4'd1, 1'b0, 2'b00, 1'b0, 1'b0, 20);
    push_serve(4'd1, 4'd1, 1'b0);
    wait_drain();

    // Single-cycle ground glitch and a start press: both ignored
    ground(12'd50, 12'd199);
    ground(12'd50, 12'd150);
    press_start();
    repeat (5) @(negedge clk);

    push(3'd4, 4'd1, 4'd2, 1'b1, 2'b00, 1'b1, 1'b0, -1);
    ground(12'd10, 12'd199);
    wait_drain();
    ball_y = 12'd150;
    push(3'd1, 4'd1, 4'd2, 1'b1, 2'b00, 1'b0, 1'b0, 20);
    push_serve(4'd1, 4'd2, 1'b1);
    wait_drain();

    // Winning point for the right player
    push(3'd5, 4'd1, 4'd3, 1'b1, 2'b10, 1'b0, 1'b0, -1);
    ground(12'd0, 12'd250);
    wait_drain();
    ground(12'd300, 12'd250);
    repeat (10) @(negedge clk);

    // Restart from OVER
    push(3'd1, 4'd0, 4'd0, 1'b1, 2'b00, 1'b0, 1'b0, -1);
    push(3'd2, 4'd0, 4'd0, 1'b1, 2'b00, 1'b1, 1'b0, 4);
    press_start();
    ball_y = 12'd150;
    wait_drain();

    // Asynchronous reset between clock edges mid-SERVE
    push(3'd0, 4'd0, 4'd0, 1'b1, 2'b00, 1'b0, 1'b0, -1);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    wait_drain();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL queue_empty: %0d left, required 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
